perf_event_bridge: RTL
======================

// Module: perf_event_bridge
// PURPOSE
//  Hardware front end for the performance-counter control slave. Converts start/stop
//  pulses from the accelerator datapath into Avalon-MM single-cycle writes to the counter
//  slave's go/stop registers, so sections are timed without CPU involvement.
//  Sits between the accelerator and the counter's control slave; a 1-to-1 Avalon master.
// PARAMETERS
//  NUM_SECTIONS  4   counter sections served (1..4); section i uses slave words 4i..4i+3
//  FIFO_DEPTH    8   event-entry FIFO depth, power of 2, >=2
//  DROP_W        16  width of saturating drop counter
// PORTS
//  clk              in   1             system clock; all logic on rising edge
//  reset            in   1             asynchronous, active-high
//  start_evt        in   NUM_SECTIONS  1-cycle pulse per section: begin timing
//  stop_evt         in   NUM_SECTIONS  1-cycle pulse per section: end timing
//  clear_req        in   1             1-cycle pulse: global counter clear
//  m_address        out  4             word address to counter slave
//  m_write          out  1             write strobe
//  m_begintransfer  out  1             equals m_write (slave has no waitrequest)
//  m_writedata      out  32            write data
//  fifo_full        out  1             FIFO holds FIFO_DEPTH entries
//  drop_count       out  DROP_W        saturating count of dropped entries
//  busy             out  1             FIFO non-empty or command in flight
// BEHAVIOUR
//  Reset: all outputs 0; FIFO emptied; FSM to IDLE; drop_count 0. Reset mid-write aborts
//   the write in the same cycle (m_write deasserts asynchronously); queued events are lost.
//  Capture: each edge, if any of {clear_req, stop_evt, start_evt} is set, push one entry
//   {clear, stop[N], start[N]} holding all bits seen that cycle. No bits set -> no push.
//  Push is accepted if FIFO not full OR a pop occurs on the same edge. Otherwise the entry
//   is dropped and drop_count increments (saturates at all-ones, never wraps).
//  FSM (2 states), state and cmd register are registered; m_* decode from cmd only
//   (no combinational path from inputs to m_*):
//   IDLE : FIFO non-empty -> pop into cmd, go ISSUE.
//   ISSUE: issue one write per cycle for the highest-priority set bit in cmd, then clear
//          that bit. Priority: clear, then stop[0..N-1], then start[0..N-1].
//          On the edge retiring the last set bit: FIFO non-empty -> pop next into cmd and
//          stay in ISSUE (no gap); else -> IDLE.
//  Write encoding (m_write = m_begintransfer = 1 for exactly one cycle per command):
//   clear    -> address 0,      writedata 32'h1
//   stop[i]  -> address 4i,     writedata 32'h0
//   start[i] -> address 4i+1,   writedata 32'h0
//   m_address/m_writedata are 0 whenever m_write is 0.
//  Latency: event sampled at edge T -> write driven during cycle T+1..T+2 (empty FIFO,
//   IDLE), slave samples it at edge T+2. Entry with k bits occupies k consecutive cycles.
//  Same-section start and stop in the same cycle: stop is written before start.
//  Ordering across entries is strictly FIFO; no merging or reordering of entries.
//  Inputs for sections >= NUM_SECTIONS do not exist; address never exceeds 4*NUM_SECTIONS-3.
//  busy = FIFO non-empty | (state == ISSUE); fifo_full is combinational from the count.
// TESTING
//  1 start_evt=4'b0100 for one cycle at edge T -> one write addr 9, data 0, sampled at T+2;
//    busy low again after T+2.
//  2 clear_req + stop_evt[1] + start_evt[3] same cycle -> consecutive writes addr 0/data 1,
//    addr 4/data 0, addr 13/data 0; no idle cycle between them.
//  3 start_evt[0] at T, stop_evt[0] at T+1 -> writes addr 1 then addr 0 on consecutive
//    cycles; with counter slave attached, time_counter_0 advances by 1, event_counter_0 = 1.
//  4 All 9 bits set for 20 consecutive cycles (depth 8) -> 11 entries accepted, 99 writes
//    issued, drop_count = 9, fifo_full high from edge T9 to T18 except after pops.
//  5 Assert reset during second write of scenario 2 -> m_write low immediately, no further
//    writes after release, drop_count 0, busy 0.
//  6 DROP_W=4, sustained overflow -> drop_count saturates at 15, never wraps to 0.

Source files
------------

// File: rtl/perf_event_bridge_if.sv
// Avalon-MM write-only master bundle between the event bridge and the
// performance counter's control slave (no waitrequest, no readback).
interface perf_event_bridge_if;
  logic [3:0]  m_address;
  logic        m_write;
  logic        m_begintransfer;
  logic [31:0] m_writedata;

  modport master (
    output m_address,
    output m_write,
    output m_begintransfer,
    output m_writedata
  );

  modport slave (
    input m_address,
    input m_write,
    input m_begintransfer,
    input m_writedata
  );
endinterface

// File: rtl/perf_event_bridge.sv
// Queues per-section start/stop pulses and global clears from the datapath and
// replays each captured bit as one single-cycle write to the counter slave.
module perf_event_bridge #(
  parameter int NUM_SECTIONS = 4,
  parameter int FIFO_DEPTH   = 8,
  parameter int DROP_W       = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_SECTIONS-1:0] start_evt,
  input  logic [NUM_SECTIONS-1:0] stop_evt,
  input  logic                    clear_req,
  perf_event_bridge_if.master     avm,
  output logic                    fifo_full,
  output logic [DROP_W-1:0]       drop_count,
  output logic                    busy
);
  localparam int ENTRY_W = 2*NUM_SECTIONS + 1;
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam int CLR_BIT = 2*NUM_SECTIONS;

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == {DROP_W{1'b1}}) ? v : v + DROP_W'(1);
  endfunction

  // Lowest-priority candidates are visited first so later matches win:
  // start[N-1..0], then stop[N-1..0], then clear.
  function automatic logic [ENTRY_W-1:0] pick_next(input logic [ENTRY_W-1:0] c);
    logic [ENTRY_W-1:0] oh;
    logic [ENTRY_W-1:0] mask;
    oh = '0;
    for (int i = NUM_SECTIONS-1; i >= 0; i--) begin
      mask = ENTRY_W'(1) << i;
      if ((c & mask) != '0) oh = mask;
    end
    for (int i = NUM_SECTIONS-1; i >= 0; i--) begin
      mask = ENTRY_W'(1) << (NUM_SECTIONS + i);
      if ((c & mask) != '0) oh = mask;
    end
    if (c[CLR_BIT]) oh = ENTRY_W'(1) << CLR_BIT;
    return oh;
  endfunction

  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   fifo_cnt;
  logic [ENTRY_W-1:0] evt_entry;
  logic [ENTRY_W-1:0] fifo_head;
  logic               fifo_empty;
  logic               push_req;
  logic               push_ok;
  logic               pop;

  state_t             state;
  state_t             state_nxt;
  logic [ENTRY_W-1:0] cmd;
  logic [ENTRY_W-1:0] cmd_nxt;
  logic [ENTRY_W-1:0] cmd_sel;
  logic [ENTRY_W-1:0] cmd_rest;
  logic               issuing;
  logic [3:0]         wr_addr;
  logic [31:0]        wr_data;

  // Capture stage: one entry per cycle holding every event bit seen
  assign evt_entry  = {clear_req, stop_evt, start_evt};
  assign push_req   = |evt_entry;
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign push_ok    = push_req && (!fifo_full || pop);
  assign fifo_head  = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= evt_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      drop_count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok && !pop)      fifo_cnt <= fifo_cnt + CNT_W'(1);
      else if (!push_ok && pop) fifo_cnt <= fifo_cnt - CNT_W'(1);
      if (push_req && !push_ok) drop_count <= sat_inc(drop_count);
    end
  end

  // Issue stage: cmd holds the bits of the entry still to be written
  assign cmd_sel  = pick_next(cmd);
  assign cmd_rest = cmd & ~cmd_sel;

  always_comb begin
    state_nxt = state;
    cmd_nxt   = cmd;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          cmd_nxt   = fifo_head;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cmd_nxt = cmd_rest;
        if (cmd_rest == '0) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            cmd_nxt = fifo_head;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cmd_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cmd   <= '0;
    end else begin
      state <= state_nxt;
      cmd   <= cmd_nxt;
    end
  end

  always_comb begin
    wr_addr = '0;
    wr_data = '0;
    for (int i = 0; i < NUM_SECTIONS; i++) begin
      if ((cmd_sel & (ENTRY_W'(1) << (NUM_SECTIONS + i))) != '0) wr_addr = 4'(4*i);
      if ((cmd_sel & (ENTRY_W'(1) << i)) != '0)                  wr_addr = 4'(4*i + 1);
    end
    if (cmd_sel[CLR_BIT]) begin
      wr_addr = 4'd0;
      wr_data = 32'h1;
    end
  end

  // Bus outputs decode from registered state/cmd only; reset clears them at once
  assign issuing             = (state == S_ISSUE) && (cmd != '0);
  assign avm.m_write         = issuing;
  assign avm.m_begintransfer = issuing;
  assign avm.m_address       = issuing ? wr_addr : 4'd0;
  assign avm.m_writedata     = issuing ? wr_data : 32'd0;
  assign busy                = !fifo_empty || (state == S_ISSUE);

endmodule
